// File: rtl/sram_ctrl_if.sv
// CPU-side request/response bus of the SRAM access controller.
// The pipeline drives requests as master; the controller answers as slave.
interface sram_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [3:0]        req_be;
    logic              busy;
    logic              ready;
    logic              err;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, req_wr, req_addr, req_wdata, req_be,
        input  busy, ready, err, rdata
    );

    modport slave (
        input  req, req_wr, req_addr, req_wdata, req_be,
        output busy, ready, err, rdata
    );
endinterface

// File: rtl/sram_ctrl.sv
// Turns single-cycle CPU requests into timed cs/oe/we sequences for an async SRAM,
// with programmable wait states and read-modify-write for byte-masked stores.
module sram_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    sram_ctrl_if.slave        bus,
    output logic              sram_cs,
    output logic              sram_oe,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    input  logic [DATA_W-1:0] sram_dout
);

    typedef enum logic [2:0] {
        IDLE, RD, WR, RMW_RD, RMW_WR, RESP, ERR
    } state_t;

    // Counter is loaded with WAIT-1 so the strobe lasts exactly WAIT cycles.
    localparam logic [3:0] RD_LOAD = 4'(RD_WAIT - 1);
    localparam logic [3:0] WR_LOAD = 4'(WR_WAIT - 1);

    state_t            state;
    logic [3:0]        cnt;
    logic [3:0]        be_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] merged;

    // Strobes and handshake are pure decodes of the state register, so an
    // asynchronous reset drops them in the same instant.
    assign sram_cs   = (state == RD) || (state == WR) || (state == RMW_RD) || (state == RMW_WR);
    assign sram_oe   = (state == RD) || (state == RMW_RD);
    assign sram_we   = (state == WR) || (state == RMW_WR);
    assign bus.busy  = (state != IDLE);
    assign bus.ready = (state == RESP) || (state == ERR);
    assign bus.err   = (state == ERR);
    assign bus.rdata = rdata_q;

    always_comb begin
        merged = sram_dout;
        for (int i = 0; i < 4; i++) begin
            if (be_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            sram_addr <= '0;
            sram_din  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        sram_addr <= bus.req_addr;
                        sram_din  <= bus.req_wdata;
                        wdata_q   <= bus.req_wdata;
                        be_q      <= bus.req_be;
                        if (bus.req_addr[1:0] != 2'b00) begin
                            state <= ERR;
                        end else if (!bus.req_wr) begin
                            state <= RD;
                            cnt   <= RD_LOAD;
                        end else if (bus.req_be == 4'hF) begin
                            state <= WR;
                            cnt   <= WR_LOAD;
                        end else if (bus.req_be == 4'h0) begin
                            state <= RESP;
                        end else begin
                            state <= RMW_RD;
                            cnt   <= RD_LOAD;
                        end
                    end
                end
                RD: begin
                    if (cnt == 4'd0) begin
                        rdata_q <= sram_dout;
                        state   <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RMW_RD: begin
                    // Merge lands directly in the din register so it is stable
                    // from the first write-strobe cycle.
                    if (cnt == 4'd0) begin
                        sram_din <= merged;
                        cnt      <= WR_LOAD;
                        state    <= RMW_WR;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                WR, RMW_WR: begin
                    if (cnt == 4'd0) state <= RESP;
                    else             cnt   <= cnt - 4'd1;
                end
                RESP, ERR: state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with a behavioural async SRAM (256 words, word-indexed by addr[9:2]).
module tb_sram_ctrl;

    logic        clk;
    logic        rst_n;
    logic        sram_cs, sram_oe, sram_we;
    logic [31:0] sram_addr, sram_din, sram_dout;

    sram_ctrl_if bus ();

    sram_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .sram_cs   (sram_cs),
        .sram_oe   (sram_oe),
        .sram_we   (sram_we),
        .sram_addr (sram_addr),
        .sram_din  (sram_din),
        .sram_dout (sram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model; the bench preloads words through the same write port.
    logic [31:0] mem [0:255];
    logic        pre_en;
    logic [7:0]  pre_idx;
    logic [31:0] pre_val;

    always @(posedge clk) begin
        if (pre_en)                mem[pre_idx]        <= pre_val;
        else if (sram_cs && sram_we) mem[sram_addr[9:2]] <= sram_din;
    end

    assign sram_dout = (sram_cs && sram_oe) ? mem[sram_addr[9:2]] : 32'hDEAD_BEEF;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] val);
        @(negedge clk);
        pre_en  = 1'b1;
        pre_idx = addr[9:2];
        pre_val = val;
        @(negedge clk);
        pre_en  = 1'b0;
    endtask

    // One request, then a fixed 12-cycle observation window (cycle 1 = first after acceptance).
    task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic poke,
                       output int rdy_cyc, output int n_rdy, output int rd_cyc,
                       output int wr_cyc, output logic err_seen, output int busy_bad);
        rdy_cyc = 0; n_rdy = 0; rd_cyc = 0; wr_cyc = 0; err_seen = 1'b0; busy_bad = 0;
        @(negedge clk);
        bus.req       = 1'b1;
        bus.req_wr    = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_be    = be;
        @(posedge clk);
        #1 bus.req = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (sram_cs && sram_oe) rd_cyc++;
            if (sram_cs && sram_we) wr_cyc++;
            if (bus.ready) begin
                n_rdy++;
                if (rdy_cyc == 0) begin
                    rdy_cyc  = k;
                    err_seen = bus.err;
                end
            end
            if (bus.busy != (rdy_cyc == 0 || rdy_cyc == k)) busy_bad++;
            if (poke && k == 1) begin
                bus.req       = 1'b1;
                bus.req_wr    = 1'b1;
                bus.req_addr  = 32'h1000_0024;
                bus.req_wdata = 32'h0000_0055;
                bus.req_be    = 4'hF;
            end else if (poke && k == 2) begin
                bus.req = 1'b0;
            end
        end
    endtask

    int   rc, nr, rdc, wrc, bb;
    logic es;
    int   cs_seen;

    initial begin
        rst_n = 1'b0;
        pre_en = 1'b0; pre_idx = '0; pre_val = '0;
        bus.req = 1'b0; bus.req_wr = 1'b0; bus.req_addr = '0; bus.req_wdata = '0; bus.req_be = '0;

        // Reset state
        preload(32'h0040_0050, 32'h8C08_0004);
        check("rst_busy",  32'(bus.busy),  0);
        check("rst_ready", 32'(bus.ready), 0);
        check("rst_err",   32'(bus.err),   0);
        check("rst_strb",  32'({sram_cs, sram_oe, sram_we}), 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_addr",  sram_addr, 0);
        check("rst_din",   sram_din,  0);
        @(negedge clk);
        rst_n = 1'b1;
        cs_seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (sram_cs || bus.busy || bus.ready) cs_seen++;
        end
        check("idle_quiet", 32'(cs_seen), 0);

        // Load, RD_WAIT=2
        txn(1'b0, 32'h0040_0050, 32'h0, 4'h0, 1'b0, rc, nr, rdc, wrc, es, bb);
        check("ld_ready_cyc", 32'(rc), 3);
        check("ld_rd_cycles", 32'(rdc), 2);
        check("ld_wr_cycles", 32'(wrc), 0);
        check("ld_err", 32'(es), 0);
        check("ld_busy", 32'(bb), 0);
        check("ld_rdata", bus.rdata, 32'h8C08_0004);

        // Full store then load
        txn(1'b1, 32'h1000_0024, 32'h0000_0007, 4'hF, 1'b0, rc, nr, rdc, wrc, es, bb);
        check("st_ready_cyc", 32'(rc), 2);
        check("st_wr_cycles", 32'(wrc), 1);
        check("st_rd_cycles", 32'(rdc), 0);
        check("st_busy", 32'(bb), 0);
        check("st_rdata_held", bus.rdata, 32'h8C08_0004);
        txn(1'b0, 32'h1000_0024, 32'h0, 4'h0, 1'b0, rc, nr, rdc, wrc, es, bb);
        check("st_readback", bus.rdata, 32'h0000_0007);

        // Partial store (read-modify-write)
        preload(32'h1000_0028, 32'h1122_3344);
        txn(1'b1, 32'h1000_0028, 32'h0000_AB00, 4'b0010, 1'b0, rc, nr, rdc, wrc, es, bb);
        check("rmw_ready_cyc", 32'(rc), 4);
        check("rmw_rd_cycles", 32'(rdc), 2);
        check("rmw_wr_cycles", 32'(wrc), 1);
        check("rmw_busy", 32'(bb), 0);
        check("rmw_rdata_held", bus.rdata, 32'h0000_0007);
        txn(1'b0, 32'h1000_0028, 32'h0, 4'h0, 1'b0, rc, nr, rdc, wrc, es, bb);
        check("rmw_readback", bus.rdata, 32'h1122_AB44);

        // Misaligned load
        txn(1'b0, 32'h1000_0026, 32'h0, 4'h0, 1'b0, rc, nr, rdc, wrc, es, bb);
        check("mis_ready_cyc", 32'(rc), 1);
        check("mis_err", 32'(es), 1);
        check("mis_strobes", 32'(rdc + wrc), 0);
        check("mis_rdata_held", bus.rdata, 32'h1122_AB44);

        // be=0 store
        txn(1'b1, 32'h1000_0028, 32'hFFFF_FFFF, 4'h0, 1'b0, rc, nr, rdc, wrc, es, bb);
        check("be0_ready_cyc", 32'(rc), 1);
        check("be0_err", 32'(es), 0);
        check("be0_strobes", 32'(rdc + wrc), 0);
        txn(1'b0, 32'h1000_0028, 32'h0, 4'h0, 1'b0, rc, nr, rdc, wrc, es, bb);
        check("be0_unchanged", bus.rdata, 32'h1122_AB44);

        // Request while busy is dropped
        txn(1'b0, 32'h0040_0050, 32'h0, 4'h0, 1'b1, rc, nr, rdc, wrc, es, bb);
        check("busy_n_ready", 32'(nr), 1);
        check("busy_ready_cyc", 32'(rc), 3);
        check("busy_wr_cycles", 32'(wrc), 0);
        txn(1'b0, 32'h1000_0024, 32'h0, 4'h0, 1'b0, rc, nr, rdc, wrc, es, bb);
        check("busy_not_written", bus.rdata, 32'h0000_0007);

        // Reset during the first RD cycle
        @(negedge clk);
        bus.req = 1'b1; bus.req_wr = 1'b0; bus.req_addr = 32'h0040_0050; bus.req_be = 4'h0;
        @(posedge clk);
        #1 bus.req = 1'b0;
        check("mid_cs_before", 32'(sram_cs), 1);
        rst_n = 1'b0;
        #1;
        check("mid_cs_after", 32'({sram_cs, sram_oe}), 0);
        check("mid_busy_after", 32'(bus.busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cs_seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.ready || bus.busy || sram_cs) cs_seen++;
        end
        check("mid_no_ready", 32'(cs_seen), 0);
        check("mid_rdata_cleared", bus.rdata, 0);
        txn(1'b0, 32'h0040_0050, 32'h0, 4'h0, 1'b0, rc, nr, rdc, wrc, es, bb);
        check("mid_recover_rc", 32'(rc), 3);
        check("mid_recover_rdata", bus.rdata, 32'h8C08_0004);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Synchronous access controller between the CPU memory stage (IF fetch or MEM load/store) and the asynchronous `sram` model.
- Converts a single-cycle request pulse into a timed `sram` cs/oe/we/addr/din sequence, with configurable wait states.
- Byte-masked stores are done by read-modify-write.
- Returns read data and a one-cycle `ready` completion pulse to the pipeline.

Parameters:
- ADDR_W, 32, byte address width (matches `sram` addr).
- DATA_W, 32, word width (matches `sram` din/dout); fixed at 32 for byte-enable logic.
- RD_WAIT, 2, cycles the read strobe (cs=1, oe=1) is held before dout is sampled; legal range 1..15.
- WR_WAIT, 1, cycles the write strobe (cs=1, we=1) is held; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  1  single-cycle request pulse; accepted only when busy=0.
- req_wr  input  1  1=store, 0=load; sampled with req.
- req_addr  input  ADDR_W  byte address; sampled with req.
- req_wdata  input  DATA_W  store data; sampled with req.
- req_be  input  4  byte enables for stores; be[0]=bits 7:0 ... be[3]=bits 31:24; ignored for loads.
- busy  output  1  high from the cycle after acceptance through the ready cycle.
- ready  output  1  one-cycle completion pulse.
- err  output  1  one-cycle pulse coincident with ready; signals a misaligned address.
- rdata  output  DATA_W  load result; valid when ready=1 and held until the next load completes.
- sram_cs  output  1  to sram cs.
- sram_oe  output  1  to sram oe.
- sram_we  output  1  to sram we.
- sram_addr  output  ADDR_W  to sram addr.
- sram_din  output  DATA_W  to sram din.
- sram_dout  input  DATA_W  from sram dout.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy, ready, err, sram_cs, sram_oe, sram_we = 0; rdata, sram_addr, sram_din = 0; wait counter = 0.
- Reset asserted mid-transaction: the transaction is abandoned immediately, sram_cs drops, and no ready is issued.
- Request capture: in IDLE, req=1 latches req_wr, req_addr, req_be and req_wdata into internal registers on the clock edge.
- req while busy=1 is ignored and never queued.
- States and transitions:
  - IDLE: on an accepted req:
    - req_addr[1:0]!=0 -> ERR.
    - load -> RD.
    - store with be=4'hF -> WR.
    - store with be=4'h0 -> RESP; no SRAM access.
    - store with any other be -> RMW_RD.
  - RD: cs=1, oe=1, we=0, sram_addr=latched addr. Counter runs RD_WAIT cycles. On the last cycle, sram_dout is captured into rdata. -> RESP.
  - WR: cs=1, oe=0, we=1, sram_din=latched wdata, held WR_WAIT cycles. -> RESP.
  - RMW_RD: same strobes as RD, but sram_dout is captured into a merge register, not rdata. -> RMW_WR.
  - RMW_WR: same strobes as WR. For each byte i, sram_din byte i = wdata byte i if be[i]=1, else merge-register byte i. -> RESP.
  - ERR: ready=1, err=1 for one cycle; no SRAM strobes ever asserted. -> IDLE.
  - RESP: ready=1 for one cycle. -> IDLE.
- Output timing:
  - sram_cs, sram_oe and sram_we are Moore outputs decoded from the state register.
  - sram_addr and sram_din come from registers; they are stable for the whole strobe and for RMW_RD->RMW_WR.
  - In IDLE, RESP and ERR, all SRAM strobes are 0.
- Latency, with acceptance edge = cycle 0:
  - load: ready in cycle RD_WAIT+1.
  - full store: ready in cycle WR_WAIT+1.
  - partial store: ready in cycle RD_WAIT+WR_WAIT+1.
  - be=0 store or misaligned access: ready in cycle 1.
- Throughput: the earliest next acceptance is the cycle after ready (IDLE).
- busy=1 in every state other than IDLE.
- rdata is unchanged by stores, errors and be=0 completions.
- The wait counter is 4 bits, loaded on state entry and decremented to 0. A transition occurs at count 0; there is no wrap.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then 1, no req -> all outputs 0; sram_cs never rises.
- Load, RD_WAIT=2: sram word @0x00400050 preloaded 0x8C080004; req load addr 0x00400050 -> cs=oe=1 for exactly 2 cycles; ready in cycle 3; rdata=0x8C080004; err=0.
- Full store then load: store 0x00000007 to 0x10000024 with be=4'hF -> we=1 for 1 cycle, ready in cycle 2; then load 0x10000024 -> rdata=0x00000007.
- Partial store: word @0x10000028=0x11223344; store be=4'b0010, wdata=0x0000AB00 -> read then write strobes, ready in cycle 4; readback=0x1122AB44.
- Misaligned and be=0: load addr 0x10000026 -> ready=err=1 in cycle 1, cs never asserted. Store be=0 -> ready in cycle 1, err=0, SRAM contents unchanged.
- Busy and reset: req pulsed again while busy -> ignored, exactly one ready. rst_n pulled low in the first RD cycle -> cs=0 immediately, no ready, state IDLE after release.
